gate_result_checker: RTL and testbench
======================================

GATE_RESULT_CHECKER -- requirements
Module: gate_result_checker

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 4, number of vectors accepted per run (>=1).
REQ-002 SHALL have parameter ERR_W, default 8, width of the error counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle pulse that begins a run.
REQ-006 abort  input  1  single-cycle pulse that terminates a run without reporting.
REQ-007 in_valid  input  1  a, b and gate_bus hold a vector this cycle.
REQ-008 a  input  1  first operand as applied to the gate stage.
REQ-009 b  input  1  second operand as applied to the gate stage.
REQ-010 gate_bus  input  7  gate-stage outputs: [0]and [1]or [2]nand [3]nor [4]not-b [5]xor [6]xnor.
REQ-011 busy  output  1  high while state is RUN.
REQ-012 done  output  1  one-cycle pulse marking the end of a run.
REQ-013 pass  output  1  high when the last completed run had zero errors.
REQ-014 err_count  output  ERR_W  count of failing vectors, saturating.
REQ-015 vec_count  output  clog2(NUM_VECTORS+1)  number of vectors accepted this run.
REQ-016 first_fail_idx  output  clog2(NUM_VECTORS+1)  index of the first failing vector.
REQ-017 first_fail_mask  output  7  mismatch bits of the first failing vector (expected XOR gate_bus).

Function
REQ-018 The block SHALL use the state machine IDLE, RUN and REPORT.
REQ-019 IDLE: start=1 and abort=0 SHALL move to RUN and, in the same edge, clear vec_count, err_count, first_fail_idx, first_fail_mask and pass.
REQ-020 RUN: each cycle with in_valid=1 SHALL compute expected = {~(a^b), a^b, ~b, ~(a|b), ~(a&b), a|b, a&b}, compare it to gate_bus, and increment vec_count.
REQ-021 A vector SHALL count as failing if any mask bit is 1; each failing vector SHALL add exactly 1 to err_count, and err_count SHALL saturate at 2^ERR_W-1.
REQ-022 The first failing vector of a run SHALL latch first_fail_idx (0-based vec_count before increment) and first_fail_mask; later failures SHALL NOT overwrite them.
REQ-023 Cycles with in_valid=0 in RUN SHALL change no counter.
REQ-024 Acceptance of vector NUM_VECTORS-1 SHALL move to REPORT; done SHALL assert on the next cycle (latency 1 cycle after the last accepted vector).
REQ-025 REPORT SHALL last exactly one cycle with done=1 and pass=(err_count==0), then return to IDLE.
REQ-026 pass, err_count, vec_count and the first_fail outputs SHALL hold their values in IDLE until the next accepted start.
REQ-027 start SHALL be ignored in RUN and REPORT; in_valid SHALL be ignored in IDLE and REPORT.
REQ-028 abort in RUN SHALL return to IDLE on the next edge with done=0 and pass=0, and SHALL still accept a coincident valid vector into the counters; abort SHALL win over start if both are high in IDLE.

Reset
REQ-029 rst_n=0 SHALL, asynchronously and in any state including mid-run, force state IDLE and drive busy, done, pass, err_count, vec_count, first_fail_idx and first_fail_mask to 0.
REQ-030 The first start SHALL be accepted on the first rising clk edge after rst_n deasserts.

Structure
REQ-031 A shared package gate_chk_pkg SHALL hold the state enum, the seven gate_bus bit-index constants and GATE_W=7.
REQ-032 The expected-vector computation SHALL live in a single combinational sub-module, gate_ref_model (a, b in; 7-bit expected out).

Verification
REQ-033 Reset, start, then vectors ab=00,01,10,11 with correct outputs -> done one cycle after the 4th vector; pass=1, err_count=0, vec_count=4.
REQ-034 Vector 3 (ab=11) with bit5 (xor) forced to 1 -> err_count=1, first_fail_idx=3, first_fail_mask=7'b0100000, pass=0.
REQ-035 Vectors 1 and 2 both failing -> err_count=2, first_fail_idx=1; three in_valid=0 gap cycles inserted between vectors leave vec_count unchanged.
REQ-036 Abort after 2 vectors -> busy=0 on the next cycle and done is never pulsed; rst_n pulsed low mid-run -> all outputs 0 immediately, without waiting for a clock edge.
REQ-037 With ERR_W=2 and NUM_VECTORS=5, all five vectors failing -> err_count=3 (saturated) and pass=0.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate-stage result checker.
// Bit positions of gate_bus and the checker FSM state encoding.
package gate_chk_pkg;

  localparam int unsigned GATE_W = 7;

  localparam int unsigned IDX_AND  = 0;
  localparam int unsigned IDX_OR   = 1;
  localparam int unsigned IDX_NAND = 2;
  localparam int unsigned IDX_NOR  = 3;
  localparam int unsigned IDX_NOTB = 4;
  localparam int unsigned IDX_XOR  = 5;
  localparam int unsigned IDX_XNOR = 6;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StReport
  } state_e;

endpackage

// File: rtl/gate_result_checker_if.sv
// Control, vector and result signals between a stimulus source and the checker.
interface gate_result_checker_if #(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned ERR_W       = 8
) ();
  import gate_chk_pkg::*;

  localparam int unsigned CntW = $clog2(NUM_VECTORS + 1);

  logic              start;
  logic              abort;
  logic              in_valid;
  logic              a;
  logic              b;
  logic [GATE_W-1:0] gate_bus;

  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [CntW-1:0]   vec_count;
  logic [CntW-1:0]   first_fail_idx;
  logic [GATE_W-1:0] first_fail_mask;

  modport master (
    output start, abort, in_valid, a, b, gate_bus,
    input  busy, done, pass, err_count, vec_count, first_fail_idx, first_fail_mask
  );

  modport slave (
    input  start, abort, in_valid, a, b, gate_bus,
    output busy, done, pass, err_count, vec_count, first_fail_idx, first_fail_mask
  );

endinterface

// File: rtl/gate_ref_model.sv
// Golden gate-stage outputs for one operand pair, packed in gate_bus bit order.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic              a,
  input  logic              b,
  output logic [GATE_W-1:0] expected
);

  always_comb begin
    expected           = '0;
    expected[IDX_AND]  = a & b;
    expected[IDX_OR]   = a | b;
    expected[IDX_NAND] = ~(a & b);
    expected[IDX_NOR]  = ~(a | b);
    expected[IDX_NOTB] = ~b;
    expected[IDX_XOR]  = a ^ b;
    expected[IDX_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_result_checker.sv
// Runs a fixed-length batch of gate-stage vectors against the reference model and
// reports error count, pass flag and the first failing vector.
module gate_result_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  gate_result_checker_if.slave bus
);

  localparam int unsigned CntW = $clog2(NUM_VECTORS + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_VECTORS - 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    vec_count_q, vec_count_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [CntW-1:0]    ff_idx_q, ff_idx_d;
  logic [GATE_W-1:0]  ff_mask_q, ff_mask_d;
  logic               pass_q, pass_d;

  logic [GATE_W-1:0]  expected;
  logic [GATE_W-1:0]  mismatch;
  logic               accept;

  gate_ref_model u_ref (
    .a        (bus.a),
    .b        (bus.b),
    .expected (expected)
  );

  assign mismatch = expected ^ bus.gate_bus;
  assign accept   = (state_q == StRun) && bus.in_valid;

  always_comb begin
    state_d     = state_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    ff_idx_d    = ff_idx_q;
    ff_mask_d   = ff_mask_q;
    pass_d      = pass_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          state_d     = StRun;
          vec_count_d = '0;
          err_count_d = '0;
          ff_idx_d    = '0;
          ff_mask_d   = '0;
          pass_d      = 1'b0;
        end
      end
      StRun: begin
        if (accept) begin
          vec_count_d = vec_count_q + CntW'(1);
          if (|mismatch) begin
            // Saturation never wraps to zero, so a zero count means no failure yet.
            if (err_count_q == '0) begin
              ff_idx_d  = vec_count_q;
              ff_mask_d = mismatch;
            end
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
          end
        end
        if (bus.abort) begin
          state_d = StIdle;
          pass_d  = 1'b0;
        end else if (accept && (vec_count_q == LastIdx)) begin
          state_d = StReport;
          pass_d  = (err_count_d == '0);
        end
      end
      StReport: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      vec_count_q <= '0;
      err_count_q <= '0;
      ff_idx_q    <= '0;
      ff_mask_q   <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      ff_idx_q    <= ff_idx_d;
      ff_mask_q   <= ff_mask_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.busy            = (state_q == StRun);
  assign bus.done            = (state_q == StReport);
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_count_q;
  assign bus.vec_count       = vec_count_q;
  assign bus.first_fail_idx  = ff_idx_q;
  assign bus.first_fail_mask = ff_mask_q;

endmodule

// File: tb/tb_gate_result_checker.sv
// Bench for gate_result_checker: table of 4-vector runs with a result scoreboard,
// plus hand sequences for abort, reset and saturation on a 5-vector, 2-bit instance.
module tb_gate_result_checker;

  logic clk;
  logic rst_n;

  gate_result_checker_if bus4 ();
  gate_result_checker_if #(.NUM_VECTORS(5), .ERR_W(2)) bus5 ();

  gate_result_checker u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  gate_result_checker #(.NUM_VECTORS(5), .ERR_W(2)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pass;
    logic [7:0] err;
    logic [2:0] vec;
    logic [2:0] idx;
    logic [6:0] mask;
  } res_t;

  // Vector i of a run lives in element [i] of the packed arrays.
  typedef struct {
    logic [3:0][1:0] ab;
    logic [3:0][6:0] flip;
    int unsigned     gap;
    logic            exp_pass;
    logic [7:0]      exp_err;
    logic [2:0]      exp_idx;
    logic [6:0]      exp_mask;
  } run_t;

  res_t sb_q[$];
  res_t mon_exp;
  run_t runs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Truth table of the gate stage, bits {xnor,xor,notb,nor,nand,or,and}.
  function automatic logic [6:0] golden(input logic [1:0] ab);
    case (ab)
      2'b00:   golden = 7'b1011100;
      2'b01:   golden = 7'b0100110;
      2'b10:   golden = 7'b0110110;
      default: golden = 7'b1000011;
    endcase
  endfunction

  task automatic drive4(input logic [1:0] ab, input logic [6:0] flip);
    bus4.a        = ab[1];
    bus4.b        = ab[0];
    bus4.gate_bus = golden(ab) ^ flip;
    bus4.in_valid = 1'b1;
  endtask

  task automatic drive5(input logic [1:0] ab, input logic [6:0] flip);
    bus5.a        = ab[1];
    bus5.b        = ab[0];
    bus5.gate_bus = golden(ab) ^ flip;
    bus5.in_valid = 1'b1;
  endtask

  // Scoreboard: every done pulse on the 4-vector instance must match a queued run.
  always @(negedge clk) begin
    if (rst_n && bus4.done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        mon_exp = sb_q.pop_front();
        chk("sb_pass",  32'(bus4.pass),            32'(mon_exp.pass));
        chk("sb_err",   32'(bus4.err_count),       32'(mon_exp.err));
        chk("sb_vec",   32'(bus4.vec_count),       32'(mon_exp.vec));
        chk("sb_idx",   32'(bus4.first_fail_idx),  32'(mon_exp.idx));
        chk("sb_mask",  32'(bus4.first_fail_mask), 32'(mon_exp.mask));
      end
    end
  end

  task automatic do_run(input run_t r);
    sb_q.push_back('{pass: r.exp_pass, err: r.exp_err, vec: 3'd4,
                     idx: r.exp_idx, mask: r.exp_mask});
    @(negedge clk);
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    chk("run_busy",      32'(bus4.busy),      32'd1);
    chk("run_clr_vec",   32'(bus4.vec_count), 32'd0);
    chk("run_clr_err",   32'(bus4.err_count), 32'd0);
    chk("run_clr_pass",  32'(bus4.pass),      32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < int'(r.gap); g++) begin
          bus4.in_valid = 1'b0;
          bus4.start    = (g == 0);
          @(negedge clk);
          chk("gap_vec", 32'(bus4.vec_count), 32'(i));
        end
      end
      bus4.start = 1'b0;
      drive4(r.ab[i], r.flip[i]);
      @(negedge clk);
    end
    bus4.in_valid = 1'b0;
    chk("done_latency", 32'(bus4.done), 32'd1);
    chk("report_busy",  32'(bus4.busy), 32'd0);
    @(negedge clk);
    chk("done_single",  32'(bus4.done), 32'd0);
    chk("hold_pass",    32'(bus4.pass), 32'(r.exp_pass));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.in_valid = 1'b0;
    bus4.a = 1'b0; bus4.b = 1'b0; bus4.gate_bus = '0;
    bus5.start = 1'b0; bus5.abort = 1'b0; bus5.in_valid = 1'b0;
    bus5.a = 1'b0; bus5.b = 1'b0; bus5.gate_bus = '0;

    runs[0] = '{ab: {2'b11, 2'b10, 2'b01, 2'b00}, flip: {7'h00, 7'h00, 7'h00, 7'h00},
                gap: 0, exp_pass: 1'b1, exp_err: 8'd0, exp_idx: 3'd0, exp_mask: 7'h00};
    runs[1] = '{ab: {2'b11, 2'b10, 2'b01, 2'b00}, flip: {7'b0100000, 7'h00, 7'h00, 7'h00},
                gap: 0, exp_pass: 1'b0, exp_err: 8'd1, exp_idx: 3'd3, exp_mask: 7'b0100000};
    runs[2] = '{ab: {2'b11, 2'b10, 2'b01, 2'b00},
                flip: {7'h00, 7'b1000000, 7'b0000001, 7'h00},
                gap: 3, exp_pass: 1'b0, exp_err: 8'd2, exp_idx: 3'd1, exp_mask: 7'b0000001};
    runs[3] = '{ab: {2'b00, 2'b01, 2'b10, 2'b11},
                flip: {7'h00, 7'b0010000, 7'h00, 7'b1111111},
                gap: 1, exp_pass: 1'b0, exp_err: 8'd2, exp_idx: 3'd0, exp_mask: 7'b1111111};

    #3;
    chk("rst_busy",  32'(bus4.busy),            32'd0);
    chk("rst_done",  32'(bus4.done),            32'd0);
    chk("rst_pass",  32'(bus4.pass),            32'd0);
    chk("rst_err",   32'(bus4.err_count),       32'd0);
    chk("rst_vec",   32'(bus4.vec_count),       32'd0);
    chk("rst_idx",   32'(bus4.first_fail_idx),  32'd0);
    chk("rst_mask",  32'(bus4.first_fail_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 4; r++) do_run(runs[r]);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // in_valid in IDLE must not disturb held results.
    @(negedge clk);
    drive4(2'b00, 7'h7f);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    chk("idle_vec",  32'(bus4.vec_count),      32'd4);
    chk("idle_err",  32'(bus4.err_count),      32'd2);
    chk("idle_idx",  32'(bus4.first_fail_idx), 32'd0);

    // abort beats start in IDLE.
    bus4.start = 1'b1; bus4.abort = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0; bus4.abort = 1'b0;
    chk("abort_start_busy", 32'(bus4.busy),      32'd0);
    chk("abort_start_vec",  32'(bus4.vec_count), 32'd4);

    // Abort after two vectors.
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    drive4(2'b00, 7'h00);
    @(negedge clk);
    drive4(2'b01, 7'h00);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.abort = 1'b1;
    @(negedge clk);
    bus4.abort = 1'b0;
    chk("abort_busy", 32'(bus4.busy),      32'd0);
    chk("abort_done", 32'(bus4.done),      32'd0);
    chk("abort_vec",  32'(bus4.vec_count), 32'd2);
    chk("abort_pass", 32'(bus4.pass),      32'd0);
    repeat (2) @(negedge clk);

    // Abort with a coincident failing vector still counts it.
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    drive4(2'b10, 7'b0000100);
    bus4.abort = 1'b1;
    @(negedge clk);
    bus4.abort = 1'b0; bus4.in_valid = 1'b0;
    chk("abv_busy", 32'(bus4.busy),            32'd0);
    chk("abv_vec",  32'(bus4.vec_count),       32'd1);
    chk("abv_err",  32'(bus4.err_count),       32'd1);
    chk("abv_mask", 32'(bus4.first_fail_mask), 32'b0000100);

    // Asynchronous reset mid-run, checked between clock edges.
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    drive4(2'b11, 7'b0000010);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    chk("pre_rst_err", 32'(bus4.err_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus4.busy),            32'd0);
    chk("arst_err",  32'(bus4.err_count),       32'd0);
    chk("arst_vec",  32'(bus4.vec_count),       32'd0);
    chk("arst_idx",  32'(bus4.first_fail_idx),  32'd0);
    chk("arst_mask", 32'(bus4.first_fail_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    chk("post_rst_start", 32'(bus4.busy), 32'd1);
    bus4.abort = 1'b1;
    @(negedge clk);
    bus4.abort = 1'b0;

    // Five failing vectors saturate a 2-bit counter.
    bus5.start = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive5(2'(i), 7'(1 << i));
      @(negedge clk);
    end
    bus5.in_valid = 1'b0;
    chk("sat_done", 32'(bus5.done),            32'd1);
    chk("sat_err",  32'(bus5.err_count),       32'd3);
    chk("sat_pass", 32'(bus5.pass),            32'd0);
    chk("sat_vec",  32'(bus5.vec_count),       32'd5);
    chk("sat_idx",  32'(bus5.first_fail_idx),  32'd0);
    chk("sat_mask", 32'(bus5.first_fail_mask), 32'b0000001);
    @(negedge clk);
    chk("sb_final", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
